// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared types and default widths for the pulse sequencer.
//   state_t       : controller states (IDLE, RUN, DONE)
//   PERIOD_W_DEF  : default width of the period field
//   BURST_W_DEF   : default width of the burst length / pulse counter
package pulse_seq_pkg;

  localparam int PERIOD_W_DEF = 8;
  localparam int BURST_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/period_tick.sv
// period_tick: programmable divide-by-P phase counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the phase at 0 (takes effect on the next edge)
//   en         : advance the phase this cycle
//   period     : divide ratio P (1..2^PERIOD_W-1)
//   tick       : combinational, high while enabled and phase == P-1
// The phase wraps back to 0 on the tick, so it always stays below P.
module period_tick #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] phase;

  assign tick = en && (phase == period - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: emits burst_len single-cycle pulses spaced period cycles
// apart after a start request, with busy/done/aborted/cfg_err status.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   continuous  : (only with PULSE_SEQ_CONTINUOUS_EN) run until abort
//   period      : pulse spacing, latched when start is accepted
//   burst_len   : pulses per burst, latched when start is accepted
//   start       : burst request, honoured only in IDLE
//   abort       : terminate a running burst
//   pulse_out   : registered one-cycle strobe
//   busy        : high while a burst runs
//   done        : one-cycle, coincident with the final pulse
//   aborted     : one-cycle, after an abort is taken
//   cfg_err     : one-cycle, start rejected for a zero config field
//   pulse_cnt   : pulses emitted in the current or last burst
// Optional build macro: PULSE_SEQ_CONTINUOUS_EN adds the continuous input;
// a burst latched as continuous ignores burst_len, never signals done and
// saturates pulse_cnt at all-ones.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int BURST_W  = BURST_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
`ifdef PULSE_SEQ_CONTINUOUS_EN
  input  logic                continuous,
`endif
  input  logic [PERIOD_W-1:0] period,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic                start,
  input  logic                abort,
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                cfg_err,
  output logic [BURST_W-1:0]  pulse_cnt
);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  cnt_d;
  logic                pulse_d, busy_d, done_d, aborted_d, cfg_err_d;
  logic                tick_clr, tick_en, tick;
  logic                cont_req, cont_q;

`ifdef PULSE_SEQ_CONTINUOUS_EN
  logic cont_d;
  assign cont_req = continuous;

  always_ff @(posedge clk) begin
    if (reset) cont_q <= 1'b0;
    else       cont_q <= cont_d;
  end

  always_comb begin
    cont_d = cont_q;
    if (state_q == IDLE && start) cont_d = cont_req;
  end
`else
  assign cont_req = 1'b0;
  assign cont_q   = 1'b0;
`endif

  period_tick #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (tick_clr),
    .en     (tick_en),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    burst_d   = burst_q;
    cnt_d     = pulse_cnt;
    pulse_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    tick_clr  = 1'b0;
    tick_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A continuous burst has no length, so only period must be nonzero.
          if (period != '0 && (burst_len != '0 || cont_req)) begin
            period_d = period;
            burst_d  = burst_len;
            cnt_d    = '0;
            busy_d   = 1'b1;
            tick_clr = 1'b1;
            state_d  = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (abort) begin
          // Abort wins over a pulse due on the same edge.
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tick_en = 1'b1;
          if (tick) begin
            pulse_d = 1'b1;
            if (cont_q) begin
              if (pulse_cnt != '1) cnt_d = pulse_cnt + 1'b1;
            end else begin
              cnt_d = pulse_cnt + 1'b1;
              if (pulse_cnt == burst_q - 1'b1) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      period_q  <= '0;
      burst_q   <= '0;
      pulse_cnt <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      burst_q   <= burst_d;
      pulse_cnt <= cnt_d;
      pulse_out <= pulse_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      cfg_err   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios followed by random traffic,
// each cycle compared against an elapsed-time reference model.
module tb_pulse_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] period = '0;
  logic [7:0] burst_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pulse_out, busy, done, aborted, cfg_err;
  logic [7:0] pulse_cnt;
`ifdef PULSE_SEQ_CONTINUOUS_EN
  logic       continuous = 1'b0;
`endif

  int ncmp = 0;
  int nfail = 0;

  // reference model state: a burst is described by its start edge and config
  int ecnt = 0;
  int mode = 0;  // 0 idle, 1 running, 2 cooldown
  int t0 = 0, mP = 0, mB = 0;
  int e_cnt = 0;
  bit e_pulse, e_busy, e_done, e_ab, e_cfg;

  always #5 clk = ~clk;

  pulse_sequencer #(.PERIOD_W(8), .BURST_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PULSE_SEQ_CONTINUOUS_EN
    .continuous(continuous),
`endif
    .period    (period),
    .burst_len (burst_len),
    .start     (start),
    .abort     (abort),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err),
    .pulse_cnt (pulse_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, ecnt, obs, exp);
    end
  endtask

  // One clock edge with the given inputs, then model update and compare.
  task automatic cyc(input bit st, input bit ab, input bit rs, input int per, input int bl);
    int k;
    start = st; abort = ab; reset = rs;
    period = per[7:0]; burst_len = bl[7:0];
    @(posedge clk);
    #1;
    ecnt++;
    e_pulse = 0; e_done = 0; e_ab = 0; e_cfg = 0;
    if (rs) begin
      mode = 0; e_cnt = 0;
    end else begin
      case (mode)
        0: if (st) begin
             if (per != 0 && bl != 0) begin
               mode = 1; t0 = ecnt; mP = per; mB = bl; e_cnt = 0;
             end else begin
               e_cfg = 1;
             end
           end
        1: begin
             k = ecnt - t0;
             if (ab) begin
               mode = 0; e_ab = 1; e_cnt = (k - 1) / mP;
             end else begin
               e_cnt = k / mP;
               if (k % mP == 0) e_pulse = 1;
               if (k == mP * mB) begin e_done = 1; mode = 2; end
             end
           end
        default: mode = 0;
      endcase
    end
    e_busy = (mode == 1);
    check("pulse_out", int'(pulse_out), int'(e_pulse));
    check("busy", int'(busy), int'(e_busy));
    check("done", int'(done), int'(e_done));
    check("aborted", int'(aborted), int'(e_ab));
    check("cfg_err", int'(cfg_err), int'(e_cfg));
    check("pulse_cnt", int'(pulse_cnt), e_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset state
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(2);

    // period 5, burst 3
    cyc(1, 0, 0, 5, 3);
    idle(17);
    check("final_cnt_s1", int'(pulse_cnt), 3);

    // period 1, burst 4: four back-to-back pulses
    cyc(1, 0, 0, 1, 4);
    idle(6);

    // zero config fields rejected
    cyc(1, 0, 0, 0, 3);
    idle(2);
    cyc(1, 0, 0, 3, 0);
    idle(2);

    // period 4, burst 10, abort on the edge of the second pulse
    cyc(1, 0, 0, 4, 10);
    idle(7);
    cyc(0, 1, 0, 0, 0);
    idle(4);
    check("abort_cnt", int'(pulse_cnt), 1);

    // start and config changes during RUN and in the DONE cycle
    cyc(1, 0, 0, 3, 4);
    for (int i = 0; i < 13; i++) cyc(1, 0, 0, 1, 1);
    idle(3);

    // reset mid-burst, then a fresh burst
    cyc(1, 0, 0, 3, 5);
    idle(6);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    cyc(1, 0, 0, 5, 3);
    idle(17);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit st, ab, rs;
      int per, bl;
      st  = ($urandom_range(0, 5) == 0);
      ab  = ($urandom_range(0, 40) == 0);
      rs  = ($urandom_range(0, 200) == 0);
      per = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      bl  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      cyc(st, ab, rs, per, bl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Controller that sequences a programmable periodic pulse generator. Software or an upstream FSM loads a period and a burst length, then issues start. The block emits exactly burst_len single-cycle pulses, spaced period cycles apart, and reports busy/done/aborted status. It sits between the control/config logic and any consumer of timed strobes (sampling enables, LED/PWM ticks, bus polling).

Parameters:
PERIOD_W, 8, width of the period input; legal period range is 1..2^PERIOD_W-1.
BURST_W, 8, width of burst_len and pulse_cnt; legal burst range is 1..2^BURST_W-1.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
period  input  PERIOD_W  cycles between pulses; sampled only when start is accepted.
burst_len  input  BURST_W  number of pulses in the burst; sampled only when start is accepted.
start  input  1  request a burst; honoured only in IDLE.
abort  input  1  terminate a running burst.
pulse_out  output  1  registered one-cycle pulse.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse, coincident with the final pulse_out.
aborted  output  1  one-cycle pulse after an abort is taken.
cfg_err  output  1  one-cycle pulse when start arrives with period==0 or burst_len==0.
pulse_cnt  output  BURST_W  pulses emitted in the current or last burst.

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE; all outputs 0; phase counter and latched config cleared.
- States:
  - IDLE: waiting for start.
  - RUN: burst in progress.
  - DONE: single-cycle cooldown after the last pulse.
- IDLE, start=1, both config fields nonzero, sampled at edge N:
  - Latch period as P and burst_len as B.
  - phase=0, pulse_cnt=0, busy=1, state=RUN.
- IDLE, start=1, period==0 or burst_len==0: cfg_err=1 for one cycle; state stays IDLE; pulse_cnt unchanged.
- RUN, each edge:
  - If phase==P-1: phase=0, pulse_out=1, pulse_cnt+=1.
  - Otherwise: phase+=1, pulse_out=0.
- Pulse timing: pulse_out is high in the cycle after edges N+P, N+2P, ..., N+B*P.
  - P=1 gives pulse_out high every cycle for B cycles.
- Final pulse (pulse_cnt reaches B), at edge N+B*P:
  - pulse_out=1, done=1, busy=0, state=DONE.
- DONE: next edge returns to IDLE with done=0 and pulse_out=0. Start seen during DONE is ignored (not queued).
- Abort in RUN:
  - Next edge: state=IDLE, busy=0, pulse_out=0, aborted=1 for one cycle; pulse_cnt holds its value.
  - Abort beats a pulse due on the same edge: no pulse and no done.
- Abort outside RUN: no effect.
- Start while busy: ignored. period/burst_len changes during RUN: ignored (latched copies are used).
- Counters never wrap:
  - phase is PERIOD_W wide and always < P.
  - pulse_cnt stops at B.
- Reset mid-burst: next edge is in IDLE with all outputs 0. No done or aborted is reported.

Optional Feature:
PULSE_SEQ_CONTINUOUS_EN
- Defined:
  - Adds input port continuous (1 bit), latched at start.
  - When latched high, burst_len is not checked (zero allowed) and the burst runs until abort.
  - pulse_cnt saturates at all-ones; done is never asserted.
  - When latched low, behaviour is identical to the undefined case.
- Undefined: the port is absent; every burst is finite.

Decomposition:
- Package pulse_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default PERIOD_W and BURST_W localparams.
- One natural sub-module: period_tick. It is a programmable divide-by-P counter with a sync clear and an enable, and outputs a one-cycle tick at phase==P-1.
- The top level holds the FSM, the latched config, pulse_cnt and the status outputs.

Test Plan:
- Reset, then period=5, burst_len=3, start at edge 0 -> pulse_out high after edges 5, 10, 15; done with the 15 pulse; busy high in cycles 1..15; pulse_cnt=3.
- period=1, burst_len=4 -> pulse_out high in 4 consecutive cycles; done on the 4th; DONE lasts 1 cycle, then IDLE.
- period=0 or burst_len=0 with start -> cfg_err=1 for one cycle; busy stays 0; no pulse_out.
- period=4, burst_len=10, abort at edge 8 (same edge a pulse is due) -> no pulse at 8; aborted=1; pulse_cnt=1; done never asserted.
- Start re-asserted during RUN and during the DONE cycle, with config inputs changed mid-burst -> both ignored; spacing stays at the original period.
- reset=1 at edge 7 of a period=3, burst_len=5 burst -> from edge 8 all outputs 0 and IDLE; a fresh start then behaves as in scenario 1.
